// File: rtl/delay_credit_buffer_if.sv
// Handshake bundle between the issuer, the external fixed-latency pipeline
// return, the consumer and the credit buffer.
interface delay_credit_buffer_if #(
  parameter int DATAWIDTH = 32
);
  logic                 s_valid;
  logic                 s_ready;
  logic                 pipe_valid;
  logic [DATAWIDTH-1:0] pipe_data;
  logic                 m_valid;
  logic [DATAWIDTH-1:0] m_data;
  logic                 m_ready;

  // Environment side: issuer, external pipeline output and consumer.
  modport master (
    output s_valid,
    input  s_ready,
    output pipe_valid,
    output pipe_data,
    input  m_valid,
    input  m_data,
    output m_ready
  );

  // Buffer side.
  modport slave (
    input  s_valid,
    output s_ready,
    input  pipe_valid,
    input  pipe_data,
    output m_valid,
    output m_data,
    input  m_ready
  );
endinterface

// File: rtl/delay_credit_buffer.sv
// Credit-based return buffer for a fixed-latency valid-only pipeline.
// Issue permission is granted only while launched-but-unreturned words plus
// buffered words leave room in the FIFO, so results always have a slot.
module delay_credit_buffer #(
  parameter  int DATAWIDTH = 32,
  parameter  int DEPTH     = 8,
  localparam int CNTW      = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  delay_credit_buffer_if.slave   bus,
  output logic [CNTW-1:0]        inflight,
  output logic [CNTW-1:0]        occupancy,
  output logic                   overflow_err
);

  localparam int              PTRW       = $clog2(DEPTH);
  localparam logic [CNTW:0]   CREDIT_MAX = (CNTW + 1)'(DEPTH);
  localparam logic [CNTW-1:0] FULL_LEVEL = CNTW'(DEPTH);

  logic [DATAWIDTH-1:0] mem [DEPTH];

  logic [PTRW-1:0] wptr_reg, wptr_next;
  logic [PTRW-1:0] rptr_reg, rptr_next;
  logic [CNTW-1:0] inflight_reg, inflight_next;
  logic [CNTW-1:0] occupancy_reg, occupancy_next;
  logic            err_reg, err_next;

  logic            issue;
  logic            push;
  logic            pop;
  logic            full;
  logic            accept_push;
  logic            spurious;
  logic            dropped;
  logic            ret_credit;
  logic [CNTW:0]   credits_used;

  // One extra bit so a corrupted (error-state) sum cannot wrap below DEPTH.
  assign credits_used = {1'b0, inflight_reg} + {1'b0, occupancy_reg};
  assign bus.s_ready  = rst_n && (credits_used < CREDIT_MAX);

  assign issue = bus.s_valid && bus.s_ready;
  assign push  = bus.pipe_valid;
  assign pop   = bus.m_valid && bus.m_ready;
  assign full  = (occupancy_reg == FULL_LEVEL);

  // A full FIFO still accepts a return when the head leaves in the same cycle.
  assign accept_push = push && (!full || pop);
  assign dropped     = push && full && !pop;
  assign spurious    = push && (inflight_reg == '0);
  // A spurious return must not wrap inflight below zero.
  assign ret_credit  = push && ((inflight_reg != '0) || issue);

  // Head is presented straight from the array; no output register, no bypass.
  assign bus.m_valid = (occupancy_reg != '0);
  assign bus.m_data  = mem[rptr_reg];

  assign inflight     = inflight_reg;
  assign occupancy    = occupancy_reg;
  assign overflow_err = err_reg;

  // Next-state arithmetic for counters, pointers and the sticky error flag.
  always_comb begin
    inflight_next  = inflight_reg + CNTW'(issue) - CNTW'(ret_credit);
    occupancy_next = occupancy_reg + CNTW'(accept_push) - CNTW'(pop);
    wptr_next      = wptr_reg + PTRW'(accept_push);
    rptr_next      = rptr_reg + PTRW'(pop);
    err_next       = err_reg | dropped | spurious;
  end

  // Control state: cleared by reset, otherwise takes the computed next values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr_reg      <= '0;
      rptr_reg      <= '0;
      inflight_reg  <= '0;
      occupancy_reg <= '0;
      err_reg       <= 1'b0;
    end else begin
      wptr_reg      <= wptr_next;
      rptr_reg      <= rptr_next;
      inflight_reg  <= inflight_next;
      occupancy_reg <= occupancy_next;
      err_reg       <= err_next;
    end
  end

  // Storage write; contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (accept_push) begin
      mem[wptr_reg] <= bus.pipe_data;
    end
  end

endmodule
